// File: rtl/ssd_pkg.sv
// Shared types, constants and segment decode for the seven-segment scan driver.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: seg_t, SEG_BLANK, SEG_DASH, state_t (load/convert FSM), seg_decode().
package ssd_pkg;

   // Active-low segment vector, bit order {a,b,c,d,e,f,g}.
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b1111110;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // BCD digit to active-low segments. Codes above 9 are shown blank.
   function automatic seg_t seg_decode(input logic [3:0] digit);
      case (digit)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Load port and display outputs of the seven-segment scan driver.
// Latency: n/a (signal bundle only).
// Backpressure: load_valid is held by the master until load_ready is seen high.
// Ports: load_valid/values (master->slave), load_ready/overflow/anode/ssd_out (slave->master).
interface ssd_scan_driver_if #(
   parameter int GROUPS = 2,
   parameter int DIGITS = 4,
   parameter int VAL_W  = 16
);
   import ssd_pkg::*;

   logic                      load_valid;
   logic                      load_ready;
   logic [GROUPS*VAL_W-1:0]   values;
   logic [GROUPS-1:0]         overflow;
   logic [GROUPS*DIGITS-1:0]  anode;
   seg_t                      ssd_out;

   modport master (
      output load_valid, values,
      input  load_ready, overflow, anode, ssd_out
   );

   modport slave (
      input  load_valid, values,
      output load_ready, overflow, anode, ssd_out
   );

endinterface

// File: rtl/ssd_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency: start cycle consumes the first bit, o_done pulses VAL_W cycles after i_start.
// Backpressure: none; a new i_start restarts the conversion unconditionally.
// Ports: clk, rst_n, i_start, i_bin (value), o_done (1-cycle pulse), o_bcd (valid while o_done).
module ssd_bin2bcd_seq #(
   parameter int VAL_W = 16,
   parameter int BCD_D = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [VAL_W-1:0]   i_bin,
   output logic               o_done,
   output logic [BCD_D*4-1:0] o_bcd
);
   localparam int BCD_W = BCD_D * 4;
   localparam int CNT_W = $clog2(VAL_W + 1);

   logic [VAL_W-1:0] r_sh;
   logic [BCD_W-1:0] r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [BCD_W-1:0] w_adj;

   // Add-3 correction on every nibble that would exceed 9 after doubling.
   always_comb begin
      w_adj = r_bcd;
      for (int n = 0; n < BCD_D; n++) begin
         if (r_bcd[n*4 +: 4] >= 4'd5) begin
            w_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh   <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (i_start) begin
         // The accumulator starts at zero, so the first step is just the MSB shift.
         r_bcd  <= {{(BCD_W-1){1'b0}}, i_bin[VAL_W-1]};
         r_sh   <= {i_bin[VAL_W-2:0], 1'b0};
         r_cnt  <= CNT_W'(1);
         r_busy <= 1'b1;
         r_done <= 1'b0;
      end else if (r_busy) begin
         // The top nibble never carries out because BCD_D covers 2^VAL_W-1.
         r_bcd <= BCD_W'({w_adj, r_sh[VAL_W-1]});
         r_sh  <= {r_sh[VAL_W-2:0], 1'b0};
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_cnt == CNT_W'(VAL_W - 1)) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end else begin
         r_done <= 1'b0;
      end
   end

   assign o_done = r_done;
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver: loads GROUPS values, converts to BCD, scans digits.
// Latency: load visible on anode/ssd_out a few cycles after GROUPS*(VAL_W+1) conversion cycles.
// Backpressure: load_ready low from the cycle after a load until the cycle after COMMIT.
// Ports: clk, rst_n, s_if (slave: load_valid/values in; load_ready/overflow/anode/ssd_out out).
// Optional: SSD_LEADING_ZERO_BLANK_EN blanks zero digits above the leading non-zero digit.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int GROUPS     = 2,
   parameter int DIGITS     = 4,
   parameter int VAL_W      = 16,
   parameter int PRESCALE_W = 18
) (
   input  logic               clk,
   input  logic               rst_n,
   ssd_scan_driver_if.slave   s_if
);
   localparam int N        = GROUPS * DIGITS;
   localparam int BCD_CALC = (VAL_W * 30103 + 99999) / 100000;
   localparam int BCD_D    = (BCD_CALC > DIGITS) ? BCD_CALC : DIGITS;
   localparam int BCD_W    = BCD_D * 4;
   localparam int DISP_W   = DIGITS * 4;
   localparam int GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t                        r_state, w_next;
   logic [GROUPS*VAL_W-1:0]       r_shadow;
   logic [GRP_W-1:0]              r_grp;
   logic                          r_first;
   logic [GROUPS-1:0][BCD_W-1:0]  r_pend;
   logic [GROUPS-1:0][DISP_W-1:0] r_disp;
   logic [GROUPS-1:0]             r_ovf;
   logic [PRESCALE_W-1:0]         r_pre;
   logic [GRP_W-1:0]              r_sg;
   logic [DIG_W-1:0]              r_sp;
   logic [N-1:0]                  r_anode;
   seg_t                          r_seg;

   logic                          w_hs, w_last_grp, w_eng_start, w_eng_done;
   logic [VAL_W-1:0]              w_eng_bin;
   logic [BCD_W-1:0]              w_eng_bcd;
   logic [DISP_W-1:0]             w_grp_disp;
   logic [3:0]                    w_nib;
   logic                          w_blank;
   seg_t                          w_seg;
   logic [N-1:0]                  w_anode;

   assign w_hs        = s_if.load_valid && (r_state == ST_IDLE);
   assign w_last_grp  = (r_grp == GRP_W'(GROUPS - 1));
   assign w_eng_start = (r_state == ST_CONV) && r_first;
   assign w_eng_bin   = r_shadow[r_grp*VAL_W +: VAL_W];

   ssd_bin2bcd_seq #(.VAL_W(VAL_W), .BCD_D(BCD_D)) u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_eng_start),
      .i_bin   (w_eng_bin),
      .o_done  (w_eng_done),
      .o_bcd   (w_eng_bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_hs) w_next = ST_CONV;
         ST_CONV:   if (w_eng_done && w_last_grp) w_next = ST_COMMIT;
         ST_COMMIT: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Conversion datapath: shadow the whole set, convert groups in turn into
   // the pending buffer, then publish everything to the display in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_grp    <= '0;
         r_first  <= 1'b0;
         r_pend   <= '0;
         r_disp   <= '0;
         r_ovf    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_hs) begin
               r_shadow <= s_if.values;
               r_grp    <= '0;
               r_first  <= 1'b1;
               r_pend   <= '0;
            end
            ST_CONV: begin
               r_first <= 1'b0;
               if (w_eng_done) begin
                  r_pend[r_grp] <= w_eng_bcd;
                  if (!w_last_grp) begin
                     r_grp   <= r_grp + GRP_W'(1);
                     r_first <= 1'b1;
                  end
               end
            end
            ST_COMMIT: for (int g = 0; g < GROUPS; g++) begin
               r_disp[g] <= r_pend[g][DISP_W-1:0];
               r_ovf[g]  <= (r_pend[g] >> DISP_W) != '0;
            end
            default: ;
         endcase
      end
   end

   // Free-running scan: digit position p within group g, advanced on prescaler wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_sg  <= '0;
         r_sp  <= '0;
      end else begin
         r_pre <= r_pre + PRESCALE_W'(1);
         if (&r_pre) begin
            if (r_sp == DIG_W'(DIGITS - 1)) begin
               r_sp <= '0;
               r_sg <= (r_sg == GRP_W'(GROUPS - 1)) ? '0 : r_sg + GRP_W'(1);
            end else begin
               r_sp <= r_sp + DIG_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_grp_disp = r_disp[r_sg];
      w_nib      = w_grp_disp[r_sp*4 +: 4];
      w_blank    = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      // Blank when this digit and everything above it is zero; p=0 always shows.
      w_blank    = (r_sp != '0) && ((w_grp_disp >> (r_sp * 4)) == '0);
`endif
      if (r_ovf[r_sg])  w_seg = SEG_DASH;
      else if (w_blank) w_seg = SEG_BLANK;
      else              w_seg = seg_decode(w_nib);
      w_anode = ~(N'(1) << (r_sg * DIGITS + r_sp));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_anode <= '1;
         r_seg   <= SEG_BLANK;
      end else begin
         r_anode <= w_anode;
         r_seg   <= w_seg;
      end
   end

   assign s_if.load_ready = (r_state == ST_IDLE);
   assign s_if.overflow   = r_ovf;
   assign s_if.anode      = r_anode;
   assign s_if.ssd_out    = r_seg;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: loads are queued as expected value sets,
// a negedge monitor pops a set when load_ready rises and checks every scanned digit.
// Scan position is predicted from the cycle count since reset release.
module tb_ssd_scan_driver;
   localparam int G  = 2;
   localparam int D  = 4;
   localparam int V  = 16;
   localparam int PW = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ssd_scan_driver_if #(.GROUPS(G), .DIGITS(D), .VAL_W(V)) bus ();

   ssd_scan_driver #(.GROUPS(G), .DIGITS(D), .VAL_W(V), .PRESCALE_W(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_if  (bus)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] digit_seg(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected pattern for decimal position p of value v on a D-digit group.
   function automatic logic [6:0] exp_seg(input int v, input int p);
      int pw = 1;
      for (int i = 0; i < p; i++) pw *= 10;
      if (v > 9999) return 7'b1111110;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (p > 0 && v < pw) return 7'b1111111;
`endif
      return digit_seg((v / pw) % 10);
   endfunction

   function automatic logic [1:0] exp_ovf(input logic [31:0] s);
      return {s[31:16] > 16'd9999, s[15:0] > 16'd9999};
   endfunction

   // ---------------- monitor ----------------
   int          k;
   logic [31:0] cur, nxt;
   bit          sw, prev_rdy;
   int          m_idx, m_g, m_p;
   logic [7:0]  m_anode;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         cur = '0; sw = 0; prev_rdy = 1'b1;
         exp_q.delete();
         check("rst_anode", 32'(bus.anode), 32'hff);
         check("rst_ssd", 32'(bus.ssd_out), 32'h7f);
         check("rst_ready", 32'(bus.load_ready), 32'd1);
         check("rst_ovf", 32'(bus.overflow), 32'd0);
      end else begin
         if (sw) begin cur = nxt; sw = 0; end
         if (bus.load_ready && !prev_rdy) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL commit_unexpected: display committed with no load queued at %0t", $time);
            end else begin
               nxt = exp_q.pop_front();
               sw  = 1;
            end
         end
         prev_rdy = bus.load_ready;
         check("overflow", 32'(bus.overflow), 32'(exp_ovf(sw ? nxt : cur)));
         if (k == 0) begin
            check("first_anode", 32'(bus.anode), 32'hff);
            check("first_ssd", 32'(bus.ssd_out), 32'h7f);
         end else begin
            m_idx   = ((k - 1) >> PW) % (G * D);
            m_g     = m_idx / D;
            m_p     = m_idx % D;
            m_anode = ~(8'd1 << m_idx);
            check("anode", 32'(bus.anode), 32'(m_anode));
            check("ssd_out", 32'(bus.ssd_out), 32'(exp_seg(int'(cur[m_g*16 +: 16]), m_p)));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; offers v and waits for acceptance. keep leaves
   // load_valid asserted so the caller can present the next set during CONV.
   task automatic load_set(input logic [31:0] v, input bit keep);
      int n = 0;
      bus.load_valid = 1'b1;
      bus.values     = v;
      while (!bus.load_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.load_ready) begin
         checks++; errors++;
         $display("FAIL load_accept: load_ready stayed %0b for %0d cycles", bus.load_ready, n);
         bus.load_valid = 1'b0;
      end else begin
         exp_q.push_back(v);
         @(negedge clk);
         check("ready_fall", 32'(bus.load_ready), 32'd0);
         if (!keep) bus.load_valid = 1'b0;
      end
   endtask

   function automatic logic [15:0] rnd_val();
      case ($urandom_range(0, 2))
         0:       return 16'($urandom_range(0, 65535));
         1:       return 16'($urandom_range(0, 9999));
         default: return 16'($urandom_range(0, 99));
      endcase
   endfunction

   initial begin
      int n;
      bus.load_valid = 1'b0;
      bus.values     = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      idle(40);

      load_set({16'd5678, 16'd1234}, 1'b0);  idle(80);
      load_set({16'd4321, 16'd65535}, 1'b0); idle(80);
      load_set({16'd0, 16'd7}, 1'b0);        idle(80);
      // Second set held through the first conversion, values changed mid-CONV.
      load_set({16'd9999, 16'd10000}, 1'b1);
      load_set({16'd100, 16'd2468}, 1'b0);   idle(80);

      for (int i = 0; i < 8; i++) begin
         load_set({rnd_val(), rnd_val()}, 1'b0);
         idle(80);
      end

      // Reset in the middle of a conversion.
      load_set({16'd1111, 16'd2222}, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_anode", 32'(bus.anode), 32'hff);
      check("midrst_ssd", 32'(bus.ssd_out), 32'h7f);
      check("midrst_ready", 32'(bus.load_ready), 32'd1);
      check("midrst_ovf", 32'(bus.overflow), 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      idle(80);

      load_set({16'd42, 16'd3}, 1'b0);
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      idle(40);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
